// File: rtl/reg_writeback_queue.sv
// Register write-back queue: circular FIFO merging load and ALU results into one RF write port.
// Optional pending-write forwarding lookup is compiled in when WB_FORWARD_EN is defined.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memValid,
  input  logic [4:0]                 memAddr,
  input  logic [31:0]                memData,
  input  logic                       aluValid,
  input  logic [4:0]                 aluAddr,
  input  logic [31:0]                aluData,
  output logic                       ready,
  output logic                       writeS,
  output logic [4:0]                 address3,
  output logic [31:0]                writeData,
  input  logic [4:0]                 fwdAddr,
  output logic                       fwdHit,
  output logic [31:0]                fwdData,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic          w_ready;
  logic          w_mem_st;
  logic          w_alu_st;
  logic          w_deq;
  logic [AW-1:0] w_alu_ptr;

  assign w_ready   = (r_count <= CW'(DEPTH - 2));
  // Writes to r0 complete the handshake but are never stored.
  assign w_mem_st  = memValid && w_ready && (memAddr != 5'd0);
  assign w_alu_st  = aluValid && w_ready && (aluAddr != 5'd0);
  assign w_deq     = (r_count != '0);
  assign w_alu_ptr = r_tail + AW'(w_mem_st);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) r_head <= r_head + AW'(1);
      r_tail  <= r_tail + AW'(w_mem_st) + AW'(w_alu_st);
      r_count <= r_count + CW'(w_mem_st) + CW'(w_alu_st) - CW'(w_deq);
    end
  end

  // Entry storage carries no reset; validity is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (w_mem_st) begin
      r_addr[r_tail] <= memAddr;
      r_data[r_tail] <= memData;
    end
    if (w_alu_st) begin
      r_addr[w_alu_ptr] <= aluAddr;
      r_data[w_alu_ptr] <= aluData;
    end
  end

  assign ready     = w_ready;
  assign count     = r_count;
  assign writeS    = w_deq;
  assign address3  = w_deq ? r_addr[r_head] : 5'd0;
  assign writeData = w_deq ? r_data[r_head] : 32'd0;

`ifdef WB_FORWARD_EN
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic [AW-1:0] w_idx;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 32'd0;
    w_idx      = '0;
    if (fwdAddr != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = r_head + AW'(i);
        if ((CW'(i) < r_count) && (r_addr[w_idx] == fwdAddr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_data[w_idx];
        end
      end
    end
  end

  assign fwdHit  = w_fwd_hit;
  assign fwdData = w_fwd_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwdAddr;
  assign fwdHit  = 1'b0;
  assign fwdData = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus randomized
// traffic with producer hold, compared each cycle against a queue-based model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          memValid = 1'b0, aluValid = 1'b0;
  logic [4:0]    memAddr = '0, aluAddr = '0, fwdAddr = '0;
  logic [31:0]   memData = '0, aluData = '0;
  logic          ready, writeS, fwdHit;
  logic [4:0]    address3;
  logic [31:0]   writeData, fwdData;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] mq[$];

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memAddr(memAddr), .memData(memData),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData),
    .ready(ready), .writeS(writeS), .address3(address3), .writeData(writeData),
    .fwdAddr(fwdAddr), .fwdHit(fwdHit), .fwdData(fwdData), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at negedge, compare outputs to the model, then
  // advance the model by what the next rising edge should do.
  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] fa, output logic acc);
    logic        e_ready, e_hit;
    logic [31:0] e_fd;
    @(negedge clk);
    memValid = mv; memAddr = ma; memData = md;
    aluValid = av; aluAddr = aa; aluData = ad;
    fwdAddr  = fa;
    #1;
    e_ready = (mq.size() <= DEPTH - 2);
    e_hit = 1'b0;
    e_fd  = 32'd0;
`ifdef WB_FORWARD_EN
    if (fa != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i][36:32] == fa) begin
          e_hit = 1'b1;
          e_fd  = mq[i][31:0];
          break;
        end
      end
    end
`endif
    chk("ready",     {31'd0, ready},  {31'd0, e_ready});
    chk("count",     32'(count),      32'(mq.size()));
    chk("writeS",    {31'd0, writeS}, {31'd0, mq.size() != 0});
    chk("address3",  32'(address3),   mq.size() != 0 ? 32'(mq[0][36:32]) : 32'd0);
    chk("writeData", writeData,       mq.size() != 0 ? mq[0][31:0] : 32'd0);
    chk("fwdHit",    {31'd0, fwdHit}, {31'd0, e_hit});
    chk("fwdData",   fwdData,         e_fd);
    if (mq.size() != 0) void'(mq.pop_front());
    if (mv && e_ready && ma != 5'd0) mq.push_back({ma, md});
    if (av && e_ready && aa != 5'd0) mq.push_back({aa, ad});
    acc = e_ready;
  endtask

  logic        acc;
  logic        pm_v, pa_v;
  logic [4:0]  pm_a, pa_a;
  logic [31:0] pm_d, pa_d;

  initial begin
    #12;
    chk("rst_ready",  {31'd0, ready},  32'd1);
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_writeS", {31'd0, writeS}, 32'd0);
    chk("rst_fwdHit", {31'd0, fwdHit}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Single load result then drain.
    step(1, 5'd5, 32'hAAAA0001, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 5'd5, acc);
    step(0, 0, 0, 0, 0, 0, 5'd5, acc);

    // Same-register mem/alu pair: program order, youngest forwarded.
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd3, acc);
    step(0, 0, 0, 0, 0, 0, 5'd3, acc);
    step(0, 0, 0, 0, 0, 0, 5'd3, acc);
    step(0, 0, 0, 0, 0, 0, 5'd3, acc);

    // Write to r0 is accepted but never stored.
    step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, acc);
    chk("r0_acc", {31'd0, acc}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, acc);

    // Saturate with both sources every cycle.
    for (int i = 0; i < 10; i++)
      step(1, 5'(1 + (2 * i) % 30), 32'h100 + i, 1, 5'(2 + (2 * i) % 30), 32'h200 + i,
           5'(1 + (2 * i) % 30), acc);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, acc);

    // Asynchronous reset with entries pending.
    step(1, 5'd7, 32'h7, 1, 5'd8, 32'h8, 0, acc);
    step(1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 0, acc);
    @(negedge clk);
    memValid = 0; aluValid = 0;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_count",  32'(count),      32'd0);
    chk("async_writeS", {31'd0, writeS}, 32'd0);
    chk("async_ready",  {31'd0, ready},  32'd1);
    chk("async_addr",   32'(address3),   32'd0);
    mq.delete();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 5'd9, acc);

    // Randomized traffic; a refused request is held until accepted.
    pm_v = 0; pa_v = 0; pm_a = 0; pa_a = 0; pm_d = 0; pa_d = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pm_v) begin
        pm_v = ($urandom_range(0, 3) != 0);
        pm_a = 5'($urandom_range(0, 7));
        pm_d = $urandom;
      end
      if (!pa_v) begin
        pa_v = ($urandom_range(0, 3) != 0);
        pa_a = 5'($urandom_range(0, 7));
        pa_d = $urandom;
      end
      step(pm_v, pm_a, pm_d, pa_v, pa_a, pa_d, 5'($urandom_range(0, 7)), acc);
      if (acc) begin
        pm_v = 0;
        pa_v = 0;
      end
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
